vga_box_renderer: RTL and testbench
===================================

VGA_BOX_RENDERER -- requirements
Module: vga_box_renderer

Interface
REQ-001 Parameter H_RES, 640, visible width in pixels.
REQ-002 Parameter V_RES, 480, visible height in lines.
REQ-003 Parameter BOX_W, 32, box width in pixels.
REQ-004 Parameter BOX_H, 32, box height in lines.
REQ-005 Parameter BG_COLOR, 6'b000001, background colour {R[1:0],G[1:0],B[1:0]}.
REQ-006 clk  input  1  single clock, pixel rate.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 x_in  input  10  current pixel column from the timing generator.
REQ-009 y_in  input  10  current line from the timing generator.
REQ-010 h_sync_in  input  1  horizontal sync from the timing generator.
REQ-011 v_sync_in  input  1  vertical sync from the timing generator.
REQ-012 active_in  input  1  high while the pixel is in the visible frame.
REQ-013 speed  input  2  step per frame minus one (step = speed+1, 1..4 px).
REQ-014 pause  input  1  high freezes box motion; sampled at the frame tick.
REQ-015 rgb  output  6  pixel colour {R[1:0],G[1:0],B[1:0]}, registered.
REQ-016 h_sync_out  output  1  h_sync_in delayed to align with rgb.
REQ-017 v_sync_out  output  1  v_sync_in delayed to align with rgb.
REQ-018 box_x  output  10  current box left edge.
REQ-019 box_y  output  10  current box top edge.
REQ-020 frame_cnt  output  8  frames elapsed since reset, wraps modulo 256.

Function
REQ-021 The frame tick SHALL be a one-cycle pulse in the cycle v_sync_in is 1 and the registered previous v_sync_in is 0.
REQ-022 On a frame tick with pause=0, the block SHALL update box_x and box_y in the following cycle and leave them constant at all other times.
REQ-023 Motion state SHALL be two 1-bit direction flags: dx (1=right) and dy (1=down), giving states DR, DL, UR, UL.
REQ-024 X update with dx=1: if box_x + step >= H_RES-BOX_W, set box_x = H_RES-BOX_W, clear dx, and bounce; otherwise add step.
REQ-025 X update with dx=0: if box_x <= step, set box_x = 0, set dx, and bounce; otherwise subtract step.
REQ-026 Y update SHALL mirror REQ-024/025 using box_y, dy, and the limit V_RES-BOX_H.
REQ-027 Bounce arithmetic SHALL be performed at 11 bits; box_x and box_y SHALL never leave [0, limit].
REQ-028 A 6-bit box_color register SHALL increment, wrapping, by exactly 1 per frame tick with any bounce; an X and Y bounce in the same tick still adds 1.
REQ-029 frame_cnt SHALL increment on every frame tick, including while paused.
REQ-030 Stage 1 SHALL register x_in, y_in, active_in, h_sync_in, v_sync_in, and the flag inside = (box_x <= x_in < box_x+BOX_W) && (box_y <= y_in < box_y+BOX_H).
REQ-031 Stage 2 SHALL register rgb = 0 if !active, else box_color if inside, else BG_COLOR, together with h_sync_out and v_sync_out.
REQ-032 rgb, h_sync_out, and v_sync_out SHALL have exactly 2 cycles of latency from the inputs.
REQ-033 A change to box_x or box_y SHALL affect the inside flag no earlier than the cycle after the update.
REQ-034 A speed change SHALL take effect at the next frame tick.

Reset
REQ-035 While rst=1, the block SHALL force box_x=0, box_y=0, dx=1, dy=1, box_color=6'b111111, frame_cnt=0, rgb=0, h_sync_out=0, v_sync_out=0, and clear all pipeline registers.
REQ-036 While rst=1, the previous-v_sync register SHALL load 1 so that no frame tick fires if v_sync_in is already high at release.
REQ-037 Asserting rst mid-frame or mid-update SHALL override every other action in that cycle.

Verification
REQ-038 Reset, then x_in=5, y_in=5, active_in=1 -> rgb=6'b111111 two cycles later; x_in=40 -> rgb=6'b000001; active_in=0 -> rgb=0.
REQ-039 Toggle h_sync_in and v_sync_in with arbitrary patterns -> h_sync_out and v_sync_out equal the inputs delayed by exactly 2 cycles.
REQ-040 speed=3, pause=0, 10 v_sync rising edges -> box_x=40, box_y=40, frame_cnt=10.
REQ-041 Force box_x=606 with dx=1 and speed=3, then a frame tick -> box_x=608, dx=0, box_color increments by 1; the next tick -> box_x=604.
REQ-042 Corner case box_x=606 and box_y=446, both moving and speed=3, then a tick -> box_x=608, box_y=448, both directions flip, box_color +1 only.
REQ-043 pause=1 across 3 ticks -> box_x and box_y unchanged and frame_cnt +3; then rst asserted with v_sync_in=1 and released -> all reset values hold and no tick fires until v_sync_in falls and rises again.

Source files
------------

// File: rtl/vga_box_renderer.sv
// Bouncing-box overlay for a VGA timing stream: the box steps once per frame,
// changes colour on every bounce, and video/syncs pass through a two-stage pipeline.
module vga_box_renderer #(
    parameter int         H_RES    = 640,
    parameter int         V_RES    = 480,
    parameter int         BOX_W    = 32,
    parameter int         BOX_H    = 32,
    parameter logic [5:0] BG_COLOR = 6'b000001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       active_in,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic [5:0] rgb,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [7:0] frame_cnt
);

    localparam logic [10:0] X_LIM   = 11'(H_RES - BOX_W);
    localparam logic [10:0] Y_LIM   = 11'(V_RES - BOX_H);
    localparam logic [10:0] BOX_W11 = 11'(BOX_W);
    localparam logic [10:0] BOX_H11 = 11'(BOX_H);

    // DR: down-right | DL: down-left | UR: up-right | UL: up-left
    typedef enum logic [1:0] {
        DR = 2'b00,
        DL = 2'b01,
        UR = 2'b10,
        UL = 2'b11
    } dir_t;

    dir_t        dir_q, dir_d;
    logic        vs_prev_q, vs_prev_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic [5:0]  color_q, color_d;
    logic [7:0]  frame_q, frame_d;

    logic        active_s1_q, active_s1_d;
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic        inside_s1_q, inside_s1_d;
    logic [5:0]  rgb_q, rgb_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;

    logic        frame_tick;
    logic        dx, dy, dx_n, dy_n;
    logic        bounce_x, bounce_y;
    logic [10:0] step, bx, by, nx, ny;
    logic [10:0] px, py;

    always_comb begin : motion_next
        frame_tick = v_sync_in & ~vs_prev_q;
        step       = 11'(speed) + 11'd1;
        bx         = {1'b0, box_x_q};
        by         = {1'b0, box_y_q};
        dx         = (dir_q == DR) || (dir_q == UR);
        dy         = (dir_q == DR) || (dir_q == DL);

        dx_n     = dx;
        dy_n     = dy;
        nx       = bx;
        ny       = by;
        bounce_x = 1'b0;
        bounce_y = 1'b0;

        if (dx) begin
            if (bx + step >= X_LIM) begin
                nx       = X_LIM;
                dx_n     = 1'b0;
                bounce_x = 1'b1;
            end else begin
                nx = bx + step;
            end
        end else begin
            if (bx <= step) begin
                nx       = '0;
                dx_n     = 1'b1;
                bounce_x = 1'b1;
            end else begin
                nx = bx - step;
            end
        end

        if (dy) begin
            if (by + step >= Y_LIM) begin
                ny       = Y_LIM;
                dy_n     = 1'b0;
                bounce_y = 1'b1;
            end else begin
                ny = by + step;
            end
        end else begin
            if (by <= step) begin
                ny       = '0;
                dy_n     = 1'b1;
                bounce_y = 1'b1;
            end else begin
                ny = by - step;
            end
        end

        vs_prev_d = v_sync_in;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        dir_d     = dir_q;
        color_d   = color_q;
        frame_d   = frame_q;

        if (frame_tick) begin
            frame_d = frame_q + 8'd1;
            if (!pause) begin
                box_x_d = 10'(nx);
                box_y_d = 10'(ny);
                unique case ({dy_n, dx_n})
                    2'b11:   dir_d = DR;
                    2'b10:   dir_d = DL;
                    2'b01:   dir_d = UR;
                    default: dir_d = UL;
                endcase
                // A simultaneous X and Y bounce still counts as one colour step.
                if (bounce_x || bounce_y) begin
                    color_d = color_q + 6'd1;
                end
            end
        end
    end

    always_comb begin : pixel_next
        px          = {1'b0, x_in};
        py          = {1'b0, y_in};
        active_s1_d = active_in;
        hs_s1_d     = h_sync_in;
        vs_s1_d     = v_sync_in;
        inside_s1_d = (px >= bx) && (px < bx + BOX_W11) &&
                      (py >= by) && (py < by + BOX_H11);

        rgb_d = 6'd0;
        if (active_s1_q) begin
            rgb_d = inside_s1_q ? color_q : BG_COLOR;
        end
        hs_out_d = hs_s1_q;
        vs_out_d = vs_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Preset high so a v_sync already asserted at release is not a tick.
            vs_prev_q   <= 1'b1;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dir_q       <= DR;
            color_q     <= 6'b111111;
            frame_q     <= '0;
            active_s1_q <= 1'b0;
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            inside_s1_q <= 1'b0;
            rgb_q       <= '0;
            hs_out_q    <= 1'b0;
            vs_out_q    <= 1'b0;
        end else begin
            vs_prev_q   <= vs_prev_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_q       <= dir_d;
            color_q     <= color_d;
            frame_q     <= frame_d;
            active_s1_q <= active_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            inside_s1_q <= inside_s1_d;
            rgb_q       <= rgb_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
        end
    end

    assign rgb        = rgb_q;
    assign h_sync_out = hs_out_q;
    assign v_sync_out = vs_out_q;
    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Self-checking bench for vga_box_renderer: directed scenarios plus randomized
// frame/pixel traffic compared against a plain-arithmetic model of box motion.
module tb_vga_box_renderer;

    localparam int         H_RES = 640;
    localparam int         V_RES = 480;
    localparam int         BOX_W = 32;
    localparam int         BOX_H = 32;
    localparam int         XL    = H_RES - BOX_W;
    localparam int         YL    = V_RES - BOX_H;
    localparam logic [5:0] BG    = 6'b000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x_in, y_in;
    logic       h_sync_in, v_sync_in, active_in;
    logic [1:0] speed;
    logic       pause;
    logic [5:0] rgb;
    logic       h_sync_out, v_sync_out;
    logic [9:0] box_x, box_y;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mx, my, mdx, mdy, mcolor, mframe;

    vga_box_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .x_in       (x_in),
        .y_in       (y_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .active_in  (active_in),
        .speed      (speed),
        .pause      (pause),
        .rgb        (rgb),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .box_x      (box_x),
        .box_y      (box_y),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcolor = 63; mframe = 0;
    endtask

    task automatic model_tick(input int spd, input bit p);
        int  st;
        bit  bnc;
        mframe = (mframe + 1) % 256;
        if (!p) begin
            st  = spd + 1;
            bnc = 0;
            if (mdx == 1) begin
                if (mx + st >= XL) begin mx = XL; mdx = 0; bnc = 1; end
                else mx = mx + st;
            end else begin
                if (mx <= st) begin mx = 0; mdx = 1; bnc = 1; end
                else mx = mx - st;
            end
            if (mdy == 1) begin
                if (my + st >= YL) begin my = YL; mdy = 0; bnc = 1; end
                else my = my + st;
            end else begin
                if (my <= st) begin my = 0; mdy = 1; bnc = 1; end
                else my = my - st;
            end
            if (bnc) mcolor = (mcolor + 1) % 64;
        end
    endtask

    function automatic logic [5:0] model_rgb(input int px, input int py, input bit act);
        if (!act) return 6'd0;
        if (px >= mx && px < mx + BOX_W && py >= my && py < my + BOX_H) return 6'(mcolor);
        return BG;
    endfunction

    task automatic do_reset();
        rst = 1; v_sync_in = 0; h_sync_in = 0; active_in = 0;
        x_in = 0; y_in = 0; speed = 0; pause = 0;
        clk1(); clk1(); clk1();
        rst = 0;
        model_reset();
        clk1();
    endtask

    task automatic frame_tick();
        v_sync_in = 1;
        clk1();
        v_sync_in = 0;
        clk1();
    endtask

    task automatic pixel(input int px, input int py, input bit act, output logic [5:0] got);
        x_in = 10'(px); y_in = 10'(py); active_in = act;
        clk1();
        clk1();
        got = rgb;
    endtask

    task automatic test_reset();
        rst = 1; v_sync_in = 1; h_sync_in = 1; active_in = 1;
        x_in = 10'd5; y_in = 10'd5; speed = 2'd3; pause = 0;
        clk1(); clk1(); clk1();
        checks++;
        if ({rgb, h_sync_out, v_sync_out, box_x, box_y, frame_cnt} !== '0)
            begin errors++; $display("FAIL reset_outputs: rgb=%0d hs=%0d vs=%0d bx=%0d by=%0d fc=%0d expected all 0",
                                     rgb, h_sync_out, v_sync_out, box_x, box_y, frame_cnt); end
        v_sync_in = 0; h_sync_in = 0;
        rst = 0;
        model_reset();
        clk1(); clk1(); clk1();
        checks++;
        if (box_x !== 10'd0 || box_y !== 10'd0 || frame_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_release: bx=%0d by=%0d fc=%0d expected 0 0 0", box_x, box_y, frame_cnt); end
    endtask

    task automatic test_pixels();
        logic [5:0] got;
        pixel(5, 5, 1, got);
        checks++;
        if (got !== 6'b111111) begin errors++; $display("FAIL pixel_inside: rgb=%b expected 111111", got); end
        pixel(40, 5, 1, got);
        checks++;
        if (got !== 6'b000001) begin errors++; $display("FAIL pixel_background: rgb=%b expected 000001", got); end
        pixel(40, 5, 0, got);
        checks++;
        if (got !== 6'b000000) begin errors++; $display("FAIL pixel_blank: rgb=%b expected 000000", got); end
        pixel(31, 31, 1, got);
        checks++;
        if (got !== 6'b111111) begin errors++; $display("FAIL pixel_last_inside: rgb=%b expected 111111", got); end
        pixel(32, 31, 1, got);
        checks++;
        if (got !== 6'b000001) begin errors++; $display("FAIL pixel_right_edge: rgb=%b expected 000001", got); end
    endtask

    task automatic test_sync_delay();
        logic hh[40];
        logic vh[40];
        active_in = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= 2) begin
                checks++;
                if (h_sync_out !== hh[i-2] || v_sync_out !== vh[i-2])
                    begin errors++; $display("FAIL sync_delay[%0d]: hs=%0d vs=%0d expected %0d %0d",
                                             i, h_sync_out, v_sync_out, hh[i-2], vh[i-2]); end
            end
            hh[i] = 1'($urandom);
            vh[i] = 1'($urandom);
            h_sync_in = hh[i];
            v_sync_in = vh[i];
            clk1();
        end
        h_sync_in = 0; v_sync_in = 0;
    endtask

    task automatic test_motion();
        speed = 2'd3; pause = 0;
        for (int i = 0; i < 10; i++) begin
            frame_tick();
            model_tick(3, 0);
        end
        checks++;
        if (box_x !== 10'd40 || box_y !== 10'd40 || frame_cnt !== 8'd10)
            begin errors++; $display("FAIL motion_10_ticks: bx=%0d by=%0d fc=%0d expected 40 40 10", box_x, box_y, frame_cnt); end
    endtask

    task automatic test_random();
        logic [5:0] got;
        int spd, px, py;
        bit p, act;
        for (int t = 0; t < 300; t++) begin
            // Mid-frame speed noise must not matter; only the value at the tick does.
            speed = 2'($urandom);
            clk1();
            spd   = int'($urandom_range(0, 3));
            p     = ($urandom_range(0, 3) == 0);
            speed = 2'(spd);
            pause = p;
            frame_tick();
            model_tick(spd, p);
            checks++;
            if (box_x !== 10'(mx) || box_y !== 10'(my) || frame_cnt !== 8'(mframe))
                begin errors++; $display("FAIL random_tick[%0d]: bx=%0d by=%0d fc=%0d expected %0d %0d %0d",
                                         t, box_x, box_y, frame_cnt, mx, my, mframe); end
            if (t % 10 == 0) begin
                for (int k = 0; k < 4; k++) begin
                    px  = mx + int'($urandom_range(0, BOX_W + 16)) - 8;
                    py  = my + int'($urandom_range(0, BOX_H + 16)) - 8;
                    if (px < 0) px = 0;
                    if (py < 0) py = 0;
                    act = ($urandom_range(0, 4) != 0);
                    pixel(px, py, act, got);
                    checks++;
                    if (got !== model_rgb(px, py, act))
                        begin errors++; $display("FAIL random_pixel[%0d] x=%0d y=%0d act=%0d: rgb=%b expected %b",
                                                 t, px, py, act, got, model_rgb(px, py, act)); end
                end
            end
        end
        pause = 0;
    endtask

    task automatic test_bounce_x();
        logic [5:0] got;
        do_reset();
        speed = 2'd3;
        force dut.box_x_q = 10'd606;
        clk1();
        release dut.box_x_q;
        mx = 606;
        frame_tick();
        model_tick(3, 0);
        checks++;
        if (box_x !== 10'd608 || box_y !== 10'd4)
            begin errors++; $display("FAIL bounce_x_clamp: bx=%0d by=%0d expected 608 4", box_x, box_y); end
        pixel(609, 5, 1, got);
        checks++;
        if (got !== 6'd0) begin errors++; $display("FAIL bounce_x_color: rgb=%b expected 000000", got); end
        frame_tick();
        model_tick(3, 0);
        checks++;
        if (box_x !== 10'd604 || box_y !== 10'd8)
            begin errors++; $display("FAIL bounce_x_reverse: bx=%0d by=%0d expected 604 8", box_x, box_y); end
        pixel(604, 8, 1, got);
        checks++;
        if (got !== 6'd0) begin errors++; $display("FAIL bounce_x_color_hold: rgb=%b expected 000000", got); end
    endtask

    task automatic test_corner();
        logic [5:0] got;
        do_reset();
        speed = 2'd3;
        force dut.box_x_q = 10'd606;
        force dut.box_y_q = 10'd446;
        clk1();
        release dut.box_x_q;
        release dut.box_y_q;
        mx = 606; my = 446;
        frame_tick();
        model_tick(3, 0);
        checks++;
        if (box_x !== 10'd608 || box_y !== 10'd448)
            begin errors++; $display("FAIL corner_clamp: bx=%0d by=%0d expected 608 448", box_x, box_y); end
        pixel(610, 450, 1, got);
        checks++;
        if (got !== 6'd0) begin errors++; $display("FAIL corner_color_once: rgb=%b expected 000000", got); end
        frame_tick();
        model_tick(3, 0);
        checks++;
        if (box_x !== 10'd604 || box_y !== 10'd444)
            begin errors++; $display("FAIL corner_both_flip: bx=%0d by=%0d expected 604 444", box_x, box_y); end
    endtask

    task automatic test_pause_reset();
        logic [5:0] got;
        int f0;
        f0 = mframe;
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            speed = 2'($urandom);
            frame_tick();
            model_tick(int'(speed), 1);
        end
        checks++;
        if (box_x !== 10'd604 || box_y !== 10'd444 || frame_cnt !== 8'(f0 + 3))
            begin errors++; $display("FAIL pause_hold: bx=%0d by=%0d fc=%0d expected 604 444 %0d",
                                     box_x, box_y, frame_cnt, (f0 + 3) % 256); end
        rst = 1; v_sync_in = 1; pause = 0; speed = 2'd3;
        clk1(); clk1();
        rst = 0;
        model_reset();
        clk1(); clk1(); clk1();
        checks++;
        if (box_x !== 10'd0 || box_y !== 10'd0 || frame_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_vsync_high: bx=%0d by=%0d fc=%0d expected 0 0 0", box_x, box_y, frame_cnt); end
        pixel(5, 5, 1, got);
        checks++;
        if (got !== 6'b111111) begin errors++; $display("FAIL reset_color: rgb=%b expected 111111", got); end
        v_sync_in = 0;
        clk1();
        v_sync_in = 1;
        clk1();
        v_sync_in = 0;
        clk1();
        model_tick(3, 0);
        checks++;
        if (box_x !== 10'd4 || box_y !== 10'd4 || frame_cnt !== 8'd1)
            begin errors++; $display("FAIL first_tick_after_reset: bx=%0d by=%0d fc=%0d expected 4 4 1", box_x, box_y, frame_cnt); end
    endtask

    initial begin
        rst = 1; x_in = 0; y_in = 0; h_sync_in = 0; v_sync_in = 0;
        active_in = 0; speed = 0; pause = 0;
        model_reset();
        test_reset();
        test_pixels();
        test_sync_delay();
        do_reset();
        test_motion();
        test_random();
        test_bounce_x();
        test_corner();
        test_pause_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
